// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: constants, FSM encoding and small byte/word helpers shared by
// the AES-128 key-schedule engine (aes_key_sched_seq) and its step logic.
// The optional reverse schedule is selected by the AES_KS_REV_EN macro.
package aes_ks_pkg;

  localparam int NK = 4;   // words per AES-128 key
  localparam int NR = 10;  // rounds; round keys 0..NR

  // Round constants, first byte only; entry i is used to derive key i+1.
  localparam logic [7:0] RCON [0:NR-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SUB     = 2'd2
  } ks_state_e;

  // Key words, element [0] is w0 (the most significant word of the key).
  typedef logic [NK-1:0][31:0] ks_words_t;

  // Cyclic left rotate of a word by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_ks_step.sv
// aes_ks_step: combinational one-round key-schedule step. Produces the word
// to send to the S-box bank and, given the bank's result, the next four
// key words. Forward always; reverse only when AES_KS_REV_EN is defined.
module aes_ks_step
  import aes_ks_pkg::*;
(
`ifdef AES_KS_REV_EN
  input  logic        i_dec,
`endif
  input  ks_words_t   i_w,
  input  logic [7:0]  i_rcon,
  input  logic [31:0] i_sub,
  output logic [31:0] o_req,
  output ks_words_t   o_w
);

  logic [31:0] w_rc;
  logic [31:0] w_f0, w_f1, w_f2, w_f3;

  assign w_rc = {i_rcon, 24'h0};

  // Forward: each word folds in the freshly computed word before it.
  always_comb begin
    w_f0 = i_w[0] ^ i_sub ^ w_rc;
    w_f1 = i_w[1] ^ w_f0;
    w_f2 = i_w[2] ^ w_f1;
    w_f3 = i_w[3] ^ w_f2;
  end

`ifdef AES_KS_REV_EN
  logic [31:0] w_r0, w_r1, w_r2, w_r3;

  // Reverse: undo the xor chain first; the S-box input is then the previous
  // round's w3, so the request depends on these words, not on i_sub.
  always_comb begin
    w_r3 = i_w[3] ^ i_w[2];
    w_r2 = i_w[2] ^ i_w[1];
    w_r1 = i_w[1] ^ i_w[0];
    w_r0 = i_w[0] ^ i_sub ^ w_rc;
  end

  assign o_req = i_dec ? rot_word(w_r3) : rot_word(i_w[3]);
  assign o_w   = i_dec ? {w_r3, w_r2, w_r1, w_r0} : {w_f3, w_f2, w_f1, w_f0};
`else
  assign o_req = rot_word(i_w[3]);
  assign o_w   = {w_f3, w_f2, w_f1, w_f0};
`endif

endmodule

// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: sequential AES-128 key schedule. Presents round keys
// one per valid/ready handshake and borrows the shared S-box bank for one
// cycle between keys; the bank request word idles at zero otherwise.
// AES_KS_REV_EN adds dec_i and the round 10 -> 0 (reverse) schedule.
module aes_key_sched_seq
  import aes_ks_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
`ifdef AES_KS_REV_EN
  input  logic         dec_i,
`endif
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [31:0]  sbb_o,
  output logic         sb_dec_o,
  input  logic [31:0]  sbb_i
);

  ks_state_e   r_state, w_next_state;
  ks_words_t   r_w, w_step_w;
  logic [3:0]  r_idx, w_idx_next, w_idx_init;
  logic [7:0]  r_rcon, w_rcon_next, w_rcon_init;
  logic [31:0] r_sbb, w_req;
  logic        r_done;
  logic        w_final, w_load, w_issue, w_finish, w_update;

  // Direction-dependent bookkeeping: index walk, rcon walk, last round.
`ifdef AES_KS_REV_EN
  logic r_dec;

  // Direction is latched once per schedule and held until the next start.
  always_ff @(posedge clk) begin
    if (rst)         r_dec <= 1'b0;
    else if (w_load) r_dec <= dec_i;
  end

  assign w_idx_init  = dec_i ? 4'(NR) : 4'd0;
  assign w_rcon_init = dec_i ? RCON[NR-1] : RCON[0];
  assign w_idx_next  = r_dec ? r_idx - 4'd1 : r_idx + 4'd1;
  // Going down, key i-1 is built with RCON[i-1]; after stepping to index n
  // the next step needs RCON[n-1] = RCON[r_idx-2]. Past round 1 it is unused.
  assign w_rcon_next = r_dec ? ((r_idx >= 4'd2) ? RCON[r_idx - 4'd2] : 8'h00)
                             : xtime(r_rcon);
  assign w_final     = r_dec ? (r_idx == 4'd0) : (r_idx == 4'(NR));
`else
  assign w_idx_init  = 4'd0;
  assign w_rcon_init = RCON[0];
  assign w_idx_next  = r_idx + 4'd1;
  assign w_rcon_next = xtime(r_rcon);
  assign w_final     = (r_idx == 4'(NR));
`endif

  aes_ks_step u_step (
`ifdef AES_KS_REV_EN
    .i_dec  (r_dec),
`endif
    .i_w    (r_w),
    .i_rcon (r_rcon),
    .i_sub  (sbb_i),
    .o_req  (w_req),
    .o_w    (w_step_w)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: present a key, borrow the S-box for one cycle, repeat.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start_i)    w_next_state = PRESENT;
      PRESENT: if (rk_ready_i) w_next_state = w_final ? IDLE : SUB;
      SUB:                     w_next_state = PRESENT;
      default:                 w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs and datapath strobes.
  always_comb begin
    rk_valid_o = 1'b0;
    busy_o     = 1'b1;
    w_load     = 1'b0;
    w_issue    = 1'b0;
    w_finish   = 1'b0;
    w_update   = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        w_load = start_i;
      end
      PRESENT: begin
        rk_valid_o = 1'b1;
        w_issue    = rk_ready_i & ~w_final;
        w_finish   = rk_ready_i &  w_final;
      end
      SUB:     w_update = 1'b1;
      default: busy_o   = 1'b0;
    endcase
  end

  // Key words, round index and round constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w    <= '0;
      r_idx  <= 4'd0;
      r_rcon <= 8'h00;
    end else if (w_load) begin
      r_w[0] <= key_i[127:96];
      r_w[1] <= key_i[95:64];
      r_w[2] <= key_i[63:32];
      r_w[3] <= key_i[31:0];
      r_idx  <= w_idx_init;
      r_rcon <= w_rcon_init;
    end else if (w_update) begin
      r_w    <= w_step_w;
      r_idx  <= w_idx_next;
      r_rcon <= w_rcon_next;
    end
  end

  // S-box request is live only for the SUB cycle; zero otherwise so the bank
  // sees no toggling between lookups. done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sbb  <= 32'h0;
      r_done <= 1'b0;
    end else begin
      r_sbb  <= w_issue ? w_req : 32'h0;
      r_done <= w_finish;
    end
  end

  assign rk_o     = {r_w[0], r_w[1], r_w[2], r_w[3]};
  assign rk_idx_o = r_idx;
  assign done_o   = r_done;
  assign sbb_o    = r_sbb;
  assign sb_dec_o = 1'b0;

endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Sequential AES-128 key-schedule engine that emits round keys 0..10, one per handshake, to the round datapath. It has no S-boxes of its own. SubWord is requested from the shared 32-bit, 4-byte S-box bank through a word-request port, so the engine is the client/driver side of that bank's interface. Between lookups, the request word is held at zero to keep idle switching activity low for power-analysis work.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 are package constants)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  begin a schedule; sampled only in IDLE
- key_i  in  128  cipher key (w0 = [127:96]); with AES_KS_REV_EN and dec_i=1, this is the round-10 key
- dec_i  in  1  direction, sampled with start_i; exists only with AES_KS_REV_EN
- rk_o  out  128  current round key
- rk_idx_o  out  4  round index of rk_o (0..10)
- rk_valid_o  out  1  rk_o/rk_idx_o valid
- rk_ready_i  in  1  consumer accepts rk_o when rk_valid_o=1
- busy_o  out  1  1 in any state other than IDLE
- done_o  out  1  one-cycle pulse after the final key is accepted
- sbb_o  out  32  word to S-box bank input
- sb_dec_o  out  1  S-box direction to bank; constant 0 (forward S-box only)
- sbb_i  in  32  combinational S-box bank result for sbb_o

## Operation
- States: IDLE, PRESENT, SUB.
- IDLE, start_i=1: load key_i into w0..w3, set idx (0, or 10 in reverse), set rcon (0x01, or 0x36 in reverse), go to PRESENT.
- IDLE, start_i=0: stay in IDLE.
- PRESENT: rk_valid_o=1.
  - On rk_valid_o & rk_ready_i with final idx (10 forward, 0 reverse): go to IDLE and pulse done_o.
  - On any other handshake: drive sbb_o (registered), go to SUB.
- SUB (exactly one cycle): capture sbb_i, update w0..w3, idx, and rcon, then go to PRESENT.
- Forward step:
  - sbb_o = RotWord(w3) = {w3[23:0], w3[31:24]}
  - w0' = w0 ^ sbb_i ^ {rcon, 24'h0}
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - idx+1; rcon = xtime(rcon) with 0x1b reduction
- Reverse step (AES_KS_REV_EN):
  - w3p = w3 ^ w2; w2p = w2 ^ w1; w1p = w1 ^ w0
  - sbb_o = RotWord(w3p)
  - w0p = w0 ^ sbb_i ^ {rcon, 24'h0}
  - idx-1; rcon = next entry down the RCON table
  - w3p is computed combinationally in PRESENT and registered into sbb_o.
- sbb_o = 32'h0 in every state except SUB.
- start_i while busy_o=1 is ignored; key_i and dec_i are not re-sampled.
- rk_valid_o stays asserted in PRESENT until accepted; rk_o is stable while valid and not accepted.
- rst at any time, including mid-schedule: immediate return to IDLE; the pending key is discarded and no done_o pulse is issued.

## Timing
- Reset values: rk_o=0, rk_idx_o=0, rk_valid_o=0, busy_o=0, done_o=0, sbb_o=0, sb_dec_o=0.
- start_i at edge t → rk_valid_o=1 with round 0 (or 10) from cycle t+1.
- Handshake at edge t → SUB in cycle t+1 (sbb_o valid) → next key valid from cycle t+2.
- Throughput: one key per 2 cycles with rk_ready_i held at 1; a full schedule takes 1 + 11 + 10 = 22 cycles from start to done_o.
- done_o is asserted in the cycle after the final handshake; busy_o=0 in that same cycle.
- start_i is accepted in the same cycle as done_o (FSM is already in IDLE).
- The S-box path is purely combinational: sbb_o is registered, sbb_i is registered into w0..w3, one cycle apart.

## Configuration
- AES_KS_REV_EN defined: the dec_i port exists and reverse scheduling (round 10 → 0) is supported.
- AES_KS_REV_EN undefined: no dec_i port; forward only; reverse logic and the RCON down-table are not built.

## Structure
- Package aes_ks_pkg contains:
  - NR=10
  - 10-entry RCON table (01,02,04,08,10,20,40,80,1b,36)
  - state enum {IDLE, PRESENT, SUB}
  - RotWord and xtime functions
- Sub-module aes_ks_step: combinational next-words logic (both directions), fed by the S-box result. The FSM, registers, and handshake stay in the top module.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1 → idx 0..10, idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6, done_o at cycle 22.
- Reverse (AES_KS_REV_EN): key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, dec_i=1 → idx 10..0, final rk_o=2b7e151628aed2a6abf7158809cf4f3c.
- Random rk_ready_i backpressure (30% high) → identical key sequence; rk_o stable while valid and not ready; sbb_o=0 outside SUB.
- start_i pulsed while busy_o=1 with a different key → ignored; original schedule completes unchanged.
- rst asserted in SUB at idx 5 → next cycle all outputs at reset values; a new start_i then yields round 0 one cycle later.
- Back-to-back: start_i in the done_o cycle → new round 0 valid on the next cycle; sb_dec_o=0 throughout.
